// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Two-digit BCD modulo counter for the clock/timer datapath. A single
//   parameterisation covers seconds/minutes (0-59), hours (0-23) and
//   12-hour displays (1-12). Stages cascade through EN (carry in) and
//   CA (carry out). Manual INC/DEC are provided for setting mode, plus a
//   range-checked synchronous parallel load with a one-cycle error pulse.
//
// Parameters
//   MODULO  : number of distinct states, 2..99
//   MIN_VAL : lowest count value, 0 or 1 (MAX_VAL = MIN_VAL+MODULO-1 <= 99)
//   QHW     : width of the tens digit
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active low
//   EN         in   cascade count-up enable (carry from lower stage)
//   INC        in   manual increment, never produces CA
//   DEC        in   manual decrement
//   LOAD       in   parallel load strobe
//   LDL [3:0]  in   load value, units digit
//   LDH [QHW]  in   load value, tens digit
//   QL  [3:0]  out  units digit (registered)
//   QH  [QHW]  out  tens digit (registered)
//   CA         out  carry to next stage (combinational)
//   ERR        out  load-error pulse (registered)

module bcd_mod_counter #(
  parameter int MODULO  = 60,
  parameter int MIN_VAL = 0,
  parameter int QHW     = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           INC,
  input  logic           DEC,
  input  logic           LOAD,
  input  logic [3:0]     LDL,
  input  logic [QHW-1:0] LDH,
  output logic [3:0]     QL,
  output logic [QHW-1:0] QH,
  output logic           CA,
  output logic           ERR
);

  localparam int MAX_VAL = MIN_VAL + MODULO - 1;

  localparam logic [3:0]     MIN_L = 4'(MIN_VAL % 10);
  localparam logic [QHW-1:0] MIN_H = QHW'(MIN_VAL / 10);
  localparam logic [3:0]     MAX_L = 4'(MAX_VAL % 10);
  localparam logic [QHW-1:0] MAX_H = QHW'(MAX_VAL / 10);

  generate
    if (MODULO < 2 || MODULO > 99 || (MIN_VAL != 0 && MIN_VAL != 1) ||
        MAX_VAL > 99 || QHW < 1 || QHW > 8 || (MAX_VAL / 10) >= (1 << QHW)) begin : g_bad_params
      $error("bcd_mod_counter: illegal MODULO/MIN_VAL/QHW combination");
    end
  endgenerate

  logic [3:0]     ql_q, ql_d;
  logic [QHW-1:0] qh_q, qh_d;
  logic           err_q, err_d;

  logic        up;
  logic        at_max;
  logic        at_min;
  logic [31:0] ld_val;
  logic        ld_ok;

  // Digit-wise equality is equivalent to comparing the full two-digit value
  // because both digits are always held in BCD range.
  assign at_max = (qh_q == MAX_H) && (ql_q == MAX_L);
  assign at_min = (qh_q == MIN_H) && (ql_q == MIN_L);
  assign up     = EN | INC;

  assign ld_val = 32'(LDH) * 32'd10 + 32'(LDL);
  assign ld_ok  = (LDL <= 4'd9) && (ld_val >= 32'(MIN_VAL)) && (ld_val <= 32'(MAX_VAL));

  always_comb begin
    ql_d  = ql_q;
    qh_d  = qh_q;
    err_d = 1'b0;
    if (LOAD) begin
      if (ld_ok) begin
        ql_d = LDL;
        qh_d = LDH;
      end else begin
        err_d = 1'b1;
      end
    end else if (DEC && !up) begin
      if (at_min) begin
        ql_d = MAX_L;
        qh_d = MAX_H;
      end else if (ql_q == 4'd0) begin
        ql_d = 4'd9;
        qh_d = qh_q - QHW'(1);
      end else begin
        ql_d = ql_q - 4'd1;
      end
    end else if (up && !DEC) begin
      if (at_max) begin
        ql_d = MIN_L;
        qh_d = MIN_H;
      end else if (ql_q == 4'd9) begin
        ql_d = 4'd0;
        qh_d = qh_q + QHW'(1);
      end else begin
        ql_d = ql_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ql_q  <= MIN_L;
      qh_q  <= MIN_H;
      err_q <= 1'b0;
    end else begin
      ql_q  <= ql_d;
      qh_q  <= qh_d;
      err_q <= err_d;
    end
  end

  // Carry is combinational so the next stage advances on the same edge as
  // this stage wraps. INC is deliberately excluded.
  assign CA  = at_max & EN & ~DEC & ~LOAD & RST;
  assign QL  = ql_q;
  assign QH  = qh_q;
  assign ERR = err_q;

endmodule
